// File: rtl/nf_cf_compress.sv
// NullFresh coordinate-function compression stage: registers 27 expanded shares per bit,
// then XOR-folds each group of 9 into one of 3 output shares. Optional NF_REMASK_EN adds fresh remasking.
module nf_cf_compress #(
  parameter int WIDTH = 4,
  parameter int NIN   = 27,
  parameter int NOUT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [WIDTH*NIN-1:0]    in_shares,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH*NOUT-1:0]   out_shares,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
`ifdef NF_REMASK_EN
  ,
  input  logic [WIDTH*2-1:0]      fresh
`endif
);

  localparam int GRP = NIN / NOUT;

  logic [WIDTH*NIN-1:0]  s1_data_reg;
  logic                  s1_v_reg;
  logic [WIDTH*NOUT-1:0] s2_data_reg;
  logic                  s2_v_reg;

  logic                  en1;
  logic                  en2;
  logic [WIDTH*NOUT-1:0] comp_next;
  logic [WIDTH*NOUT-1:0] mask_next;

  assign en2      = s1_v_reg & (~s2_v_reg | out_ready);
  assign in_ready = ~s1_v_reg | en2;
  assign en1      = in_valid & in_ready;

  // Compression folds only the stage-1 register outputs, never the raw inputs.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    for (genvar gs = 0; gs < NOUT; gs++) begin : g_share
      assign comp_next[gi*NOUT+gs] = ^s1_data_reg[gi*NIN + gs*GRP +: GRP];
    end
`ifdef NF_REMASK_EN
    // Third share absorbs r0^r1 so the recombined value is unchanged.
    assign mask_next[gi*NOUT+0] = fresh[2*gi];
    assign mask_next[gi*NOUT+1] = fresh[2*gi+1];
    assign mask_next[gi*NOUT+2] = fresh[2*gi] ^ fresh[2*gi+1];
`else
    assign mask_next[gi*NOUT +: NOUT] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg    <= 1'b0;
      s1_data_reg <= '0;
    end else if (flush) begin
      s1_v_reg    <= 1'b0;
      s1_data_reg <= '0;
    end else begin
      s1_v_reg <= en1 | (s1_v_reg & ~en2);
      if (en1) begin
        s1_data_reg <= in_shares;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_reg    <= 1'b0;
      s2_data_reg <= '0;
    end else if (flush) begin
      s2_v_reg    <= 1'b0;
      s2_data_reg <= '0;
    end else begin
      s2_v_reg <= en2 | (s2_v_reg & ~out_ready);
      if (en2) begin
        s2_data_reg <= comp_next ^ mask_next;
      end
    end
  end

  assign out_shares = s2_data_reg;
  assign out_valid  = s2_v_reg;
  assign busy       = s1_v_reg | s2_v_reg;

endmodule

// File: tb/tb_nf_cf_compress.sv
// Randomized + directed bench for nf_cf_compress with a queue-based scoreboard model.
module tb_nf_cf_compress;

  localparam int WIDTH = 4;
  localparam int NIN   = 27;
  localparam int NOUT  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [WIDTH*NIN-1:0]  in_shares = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [WIDTH*NOUT-1:0] out_shares;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  busy;
`ifdef NF_REMASK_EN
  logic [WIDTH*2-1:0]    fresh = 8'hA5;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH*NIN-1:0] q_data[$];
  int                   q_edge[$];
  int                   edge_cnt = 0;
  logic                 exp_ov;
  logic                 exp_ir;

  nf_cf_compress dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_shares  (in_shares),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_shares (out_shares),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef NF_REMASK_EN
    ,
    .fresh      (fresh)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Unshared bit i, share s = parity of the 9 coordinate functions 9s..9s+8 of that bit.
  function automatic logic [WIDTH*NOUT-1:0] model_out(input logic [WIDTH*NIN-1:0] x);
    logic [WIDTH*NOUT-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int s = 0; s < NOUT; s++) begin
        logic p;
        p = 1'b0;
        for (int k = 0; k < 9; k++) p = p ^ x[i*27 + 9*s + k];
        r[i*3+s] = p;
      end
`ifdef NF_REMASK_EN
    for (int i = 0; i < WIDTH; i++) begin
      r[i*3+0] = r[i*3+0] ^ fresh[2*i];
      r[i*3+1] = r[i*3+1] ^ fresh[2*i+1];
      r[i*3+2] = r[i*3+2] ^ fresh[2*i] ^ fresh[2*i+1];
    end
`endif
    return r;
  endfunction

  function automatic logic [WIDTH*NIN-1:0] rand_vec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[WIDTH*NIN-1:0];
  endfunction

  // Scoreboard: FIFO of accepted vectors; head is visible one edge after it was accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst in_ready", in_ready, 1);
      check("rst out_shares", out_shares, 0);
      q_data.delete();
      q_edge.delete();
    end else begin
      exp_ov = (q_data.size() > 0) && (edge_cnt >= q_edge[0] + 1);
      exp_ir = (q_data.size() < 2) || out_ready;
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, exp_ir);
      check("busy", busy, q_data.size() > 0);
      if (exp_ov && out_valid)
        check("out_shares", out_shares, model_out(q_data[0]));
      if (flush) begin
        q_data.delete();
        q_edge.delete();
      end else begin
        if (exp_ov && out_ready) begin
          void'(q_data.pop_front());
          void'(q_edge.pop_front());
        end
        if (in_valid && exp_ir) begin
          q_data.push_back(in_shares);
          q_edge.push_back(edge_cnt + 1);
        end
      end
    end
    edge_cnt++;
  end

  task automatic single(input logic [WIDTH*NIN-1:0] x, input logic [11:0] exp, input string nm);
    int nv;
    int first;
    logic [11:0] v;
    nv = 0; first = -1; v = '0;
    @(posedge clk); #1;
    in_shares = x; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      #3;
      if (out_valid) begin
        nv++;
        if (first < 0) begin first = c; v = out_shares; end
      end
    end
    check({nm, " valid count"}, nv, 1);
    check({nm, " latency"}, first, 1);
    check({nm, " value"}, v, exp);
  endtask

  logic [WIDTH*NIN-1:0] pin_x;
  logic [11:0]          held;
  int nv, run, maxrun, acc;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
`ifndef NF_REMASK_EN
    pin_x = '0; pin_x[0] = 1'b1;   check("model bit0", model_out(pin_x), 12'h001);
    pin_x = '0; pin_x[9] = 1'b1;   check("model bit9", model_out(pin_x), 12'h002);
    pin_x = '0; pin_x[27] = 1'b1;  check("model bit27", model_out(pin_x), 12'h008);
    pin_x = '0; pin_x[107] = 1'b1; check("model bit107", model_out(pin_x), 12'h800);
`endif
    pin_x = '1; check("model ones", model_out(pin_x), 12'hFFF ^ model_out('0));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    pin_x = '0; pin_x[0] = 1'b1;
`ifdef NF_REMASK_EN
    single(pin_x, 12'hDAC, "single");
    single('1, 12'h252, "parity");
`else
    single(pin_x, 12'h001, "single");
    single('1, 12'hFFF, "parity");
`endif

    // Stream of 8 back-to-back vectors
    @(posedge clk); #1;
    out_ready = 1'b1; nv = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_shares = rand_vec();
      #3;
      if (c < 8) check("stream in_ready", in_ready, 1);
      if (out_valid) begin nv++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream count", nv, 8);
    check("stream consecutive", maxrun, 8);

    // Backpressure: two accepts then stall with stable output
    out_ready = 1'b0; acc = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_shares = rand_vec();
      #3;
      if (in_ready) acc++;
      if (c == 2) held = out_shares;
      if (c == 4) begin
        check("bp stable", out_shares, held);
        check("bp in_ready low", in_ready, 0);
      end
      @(posedge clk); #1;
    end
    check("bp accepts", acc, 2);
    in_valid = 1'b0; out_ready = 1'b1; nv = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (out_valid) nv++;
      @(posedge clk); #1;
    end
    check("bp drained", nv, 2);

    // Flush with both stages full; offered input must be dropped
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_shares = rand_vec();
      @(posedge clk); #1;
    end
    flush = 1'b1; out_ready = 1'b1; in_shares = rand_vec();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #3;
    check("flush out_valid", out_valid, 0);
    check("flush busy", busy, 0);
    check("flush out_shares", out_shares, 0);
    check("flush in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic with rare flushes and one asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 60) == 0;
      in_shares = rand_vec();
      if (c == 700) begin
        in_valid = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst busy", busy, 0);
        check("async rst out_shares", out_shares, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #4;
    check("final idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
